// File: rtl/vga_frame_reader_pkg.sv
// Default 640x480@60 timing plus the 32x32 image-buffer geometry shared by the
// frame reader and its tick generator.
package vga_frame_reader_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int unsigned IMG_W  = 32;
    localparam int unsigned IMG_H  = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned RGB_W  = 12;
    localparam int unsigned CNT_W  = 11;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [RGB_W-1:0] rgb_t;

    typedef struct packed {
        logic active;
        logic win;
        logic hs;
        logic vs;
        logic first;
    } scan_flags_t;

    function automatic logic in_range(input cnt_t x, input cnt_t lo, input cnt_t hi);
        return (x >= lo) && (x <= hi);
    endfunction

    // Image row/column index of a screen coordinate already known to lie inside the window.
    function automatic logic [IDX_W-1:0] win_index(input cnt_t pos, input cnt_t origin,
                                                   input int unsigned shift);
        return IDX_W'((pos - origin) >> shift);
    endfunction

endpackage

// File: rtl/vga_frame_reader_pixel_tick_gen.sv
// Pixel-tick strobe: one system clock high out of every CLK_DIV, held idle while
// disabled so a re-enabled scan starts from a known phase.
module vga_frame_reader_pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_o = en_i && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_frame_reader.sv
// VGA scan reader: raster counters, image-window address generation (stage A) and
// registered colour/sync outputs one pixel tick later (stage B).
module vga_frame_reader #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_ACTIVE    = vga_frame_reader_pkg::H_ACTIVE,
    parameter int unsigned H_FP        = vga_frame_reader_pkg::H_FP,
    parameter int unsigned H_SYNC      = vga_frame_reader_pkg::H_SYNC,
    parameter int unsigned H_BP        = vga_frame_reader_pkg::H_BP,
    parameter int unsigned V_ACTIVE    = vga_frame_reader_pkg::V_ACTIVE,
    parameter int unsigned V_FP        = vga_frame_reader_pkg::V_FP,
    parameter int unsigned V_SYNC      = vga_frame_reader_pkg::V_SYNC,
    parameter int unsigned V_BP        = vga_frame_reader_pkg::V_BP,
    parameter int unsigned SCALE_SHIFT = 3,
    parameter int unsigned X0          = 192,
    parameter int unsigned Y0          = 112,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] rd_addr,
    input  logic [3:0] pix_r,
    input  logic [3:0] pix_g,
    input  logic [3:0] pix_b,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    import vga_frame_reader_pkg::*;

    localparam int unsigned WIN_W = IMG_W << SCALE_SHIFT;
    localparam int unsigned WIN_H = IMG_H << SCALE_SHIFT;

    localparam cnt_t H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t H_ACT  = CNT_W'(H_ACTIVE);
    localparam cnt_t V_ACT  = CNT_W'(V_ACTIVE);
    localparam cnt_t X_LO   = CNT_W'(X0);
    localparam cnt_t X_HI   = CNT_W'(X0 + WIN_W - 1);
    localparam cnt_t Y_LO   = CNT_W'(Y0);
    localparam cnt_t Y_HI   = CNT_W'(Y0 + WIN_H - 1);
    localparam cnt_t HS_LO  = CNT_W'(H_ACTIVE + H_FP);
    localparam cnt_t HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t VS_LO  = CNT_W'(V_ACTIVE + V_FP);
    localparam cnt_t VS_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic tick;

    vga_frame_reader_pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk_i (clk),
        .rst_ni(rst),
        .en_i  (en),
        .tick_o(tick)
    );

    cnt_t              h_q, h_d;
    cnt_t              v_q, v_d;
    scan_flags_t       flags_q, flags_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    rgb_t              rgb_q, rgb_d;
    logic              hsync_q;
    logic              vsync_q;
    logic              frame_start_q;

    always_comb begin
        h_d = h_q + CNT_W'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
        end

        flags_d        = '0;
        flags_d.active = (h_q < H_ACT) && (v_q < V_ACT);
        flags_d.win    = flags_d.active && in_range(h_q, X_LO, X_HI) && in_range(v_q, Y_LO, Y_HI);
        flags_d.hs     = in_range(h_q, HS_LO, HS_HI);
        flags_d.vs     = in_range(v_q, VS_LO, VS_HI);
        flags_d.first  = (h_q == '0) && (v_q == '0);

        rd_addr_d = rd_addr_q;
        if (flags_d.win) begin
            rd_addr_d = {win_index(v_q, Y_LO, SCALE_SHIFT), win_index(h_q, X_LO, SCALE_SHIFT)};
        end

        rgb_d = '0;
        if (flags_q.win) begin
            rgb_d = {pix_r, pix_g, pix_b};
        end else if (flags_q.active) begin
            rgb_d = BG_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q           <= '0;
            v_q           <= '0;
            flags_q       <= '0;
            rd_addr_q     <= '0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else if (!en) begin
            // Stage-A flags are cleared too, so the first output after re-enable is blank.
            h_q           <= '0;
            v_q           <= '0;
            flags_q       <= '0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (tick) begin
                h_q           <= h_d;
                v_q           <= v_d;
                flags_q       <= flags_d;
                rd_addr_q     <= rd_addr_d;
                rgb_q         <= rgb_d;
                hsync_q       <= ~flags_q.hs;
                vsync_q       <= ~flags_q.vs;
                frame_start_q <= flags_q.first;
            end
        end
    end

    assign rd_addr     = rd_addr_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader on a shrunken raster (112x87, 2x replication)
// with a memory model that returns the read address as the pixel colour.
module tb_vga_frame_reader;

    localparam int CD    = 2;
    localparam int HA    = 96;
    localparam int HF    = 4;
    localparam int HS    = 8;
    localparam int HB    = 4;
    localparam int VA    = 80;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 3;
    localparam int SS    = 1;
    localparam int XX0   = 16;
    localparam int YY0   = 8;
    localparam int HT    = HA + HF + HS + HB;
    localparam int VT    = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int WIN   = 32 << SS;
    localparam logic [11:0] BG = 12'hF0F;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [9:0] rd_addr;
    logic [3:0] pix_r, pix_g, pix_b;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       hsync, vsync, frame_start;

    vga_frame_reader #(
        .CLK_DIV    (CD),
        .H_ACTIVE   (HA),
        .H_FP       (HF),
        .H_SYNC     (HS),
        .H_BP       (HB),
        .V_ACTIVE   (VA),
        .V_FP       (VF),
        .V_SYNC     (VS),
        .V_BP       (VB),
        .SCALE_SHIFT(SS),
        .X0         (XX0),
        .Y0         (YY0),
        .BG_COLOR   (BG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rd_addr    (rd_addr),
        .pix_r      (pix_r),
        .pix_g      (pix_g),
        .pix_b      (pix_b),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Image memory model: colour word equals the address it was read from.
    assign {pix_r, pix_g, pix_b} = {2'b00, rd_addr};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          due;
        int          h;
        int          v;
        bit          is_addr;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [9:0]  addr;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] exp_rgb(input int h, input int v);
        if (h >= XX0 && h < XX0 + WIN && v >= YY0 && v < YY0 + WIN)
            return 12'((((v - YY0) >> SS) * 32) + ((h - XX0) >> SS));
        if (h < HA && v < VA)
            return BG;
        return 12'h000;
    endfunction

    // Stage-B result of pixel (h,v): visible after tick number v*HT+h+2 from scan start.
    task automatic push_pix(input int base, input int h, input int v);
        exp_t e;
        e.due     = base + CD * (v * HT + h + 2);
        e.h       = h;
        e.v       = v;
        e.is_addr = 1'b0;
        e.rgb     = exp_rgb(h, v);
        e.hs      = !(h >= HA + HF && h <= HA + HF + HS - 1);
        e.vs      = !(v >= VA + VF && v <= VA + VF + VS - 1);
        e.fs      = (h == 0 && v == 0);
        e.addr    = '0;
        sb.push_back(e);
    endtask

    task automatic push_fs_low(input int base);
        exp_t e;
        e.due     = base + CD * 2 + 1;
        e.h       = 0;
        e.v       = 0;
        e.is_addr = 1'b0;
        e.rgb     = BG;
        e.hs      = 1'b1;
        e.vs      = 1'b1;
        e.fs      = 1'b0;
        e.addr    = '0;
        sb.push_back(e);
    endtask

    task automatic push_addr(input int base, input int h, input int v, input logic [9:0] a);
        exp_t e;
        e.due     = base + CD * (v * HT + h + 1);
        e.h       = h;
        e.v       = v;
        e.is_addr = 1'b1;
        e.rgb     = '0;
        e.hs      = 1'b1;
        e.vs      = 1'b1;
        e.fs      = 1'b0;
        e.addr    = a;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                chk($sformatf("sb_late(%0d,%0d)", e.h, e.v), 32'(cyc), 32'(e.due));
            end else if (e.is_addr) begin
                chk($sformatf("rd_addr(%0d,%0d)", e.h, e.v), 32'(rd_addr), 32'(e.addr));
            end else begin
                chk($sformatf("rgb(%0d,%0d)", e.h, e.v), 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
                chk($sformatf("hsync(%0d,%0d)", e.h, e.v), 32'(hsync), 32'(e.hs));
                chk($sformatf("vsync(%0d,%0d)", e.h, e.v), 32'(vsync), 32'(e.vs));
                chk($sformatf("fstart(%0d,%0d)", e.h, e.v), 32'(frame_start), 32'(e.fs));
            end
        end
    end

    initial begin
        int base;
        int t0;
        int t1;
        int n;

        rst = 1'b0;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3000) @(negedge clk);

        // Reset mid-frame with en still high: reset wins.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_fstart", 32'(frame_start), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);

        rst  = 1'b1;
        base = cyc;
        push_pix(base, 0, 0);
        push_fs_low(base);
        push_pix(base, 99, 0);
        push_pix(base, 100, 0);
        push_pix(base, 107, 0);
        push_pix(base, 108, 0);
        push_pix(base, 15, 8);
        push_addr(base, 16, 8, 10'd0);
        push_pix(base, 16, 8);
        push_addr(base, 17, 8, 10'd0);
        push_pix(base, 17, 8);
        push_addr(base, 18, 8, 10'd1);
        push_pix(base, 18, 8);
        push_pix(base, 96, 10);
        push_addr(base, 47, 30, 10'd367);
        push_pix(base, 47, 30);
        push_addr(base, 80, 40, 10'd543);
        push_pix(base, 80, 40);
        push_addr(base, 79, 71, 10'd1023);
        push_pix(base, 79, 71);
        push_pix(base, 50, 72);
        push_pix(base, 10, 79);
        push_pix(base, 0, 81);
        push_pix(base, 0, 82);
        push_pix(base, 111, 83);
        push_pix(base, 0, 84);
        push_pix(base + CD * FRAME, 0, 0);
        push_pix(base + CD * FRAME, 30, 20);

        // hsync: fall position, low width and line period.
        n = 0;
        while (hsync !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        t0 = cyc;
        chk("hsync_fall", 32'(t0 - base), 32'(CD * (HA + HF + 2)));
        n = 0;
        while (hsync === 1'b0 && n < 2000) begin @(negedge clk); n++; end
        chk("hsync_low_clks", 32'(n), 32'(CD * HS));
        n = 0;
        while (hsync !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        t1 = cyc;
        chk("line_period", 32'(t1 - t0), 32'(CD * HT));

        // vsync: fall position and low width.
        n = 0;
        while (vsync !== 1'b0 && n < 30000) begin @(negedge clk); n++; end
        chk("vsync_fall", 32'(cyc - base), 32'(CD * ((VA + VF) * HT + 2)));
        n = 0;
        while (vsync === 1'b0 && n < 30000) begin @(negedge clk); n++; end
        chk("vsync_low_clks", 32'(n), 32'(CD * VS * HT));

        // Drop en just after pixel (30,20) of the second frame is shown.
        while (cyc < base + CD * (FRAME + 20 * HT + 30 + 2)) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
        chk("en_off_hsync", 32'(hsync), 32'd1);
        chk("en_off_vsync", 32'(vsync), 32'd1);
        chk("en_off_fstart", 32'(frame_start), 32'd0);
        chk("en_off_rd_addr", 32'(rd_addr), 32'd199);
        repeat (7) @(negedge clk);
        chk("en_off_hold_addr", 32'(rd_addr), 32'd199);
        chk("en_off_hold_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);

        // Re-enable: scan must restart from (0,0).
        en   = 1'b1;
        base = cyc;
        push_pix(base, 0, 0);
        push_fs_low(base);
        push_addr(base, 18, 8, 10'd1);
        push_pix(base, 18, 8);
        while (cyc < base + CD * (8 * HT + 18 + 2) + 2) @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
